// File: rtl/bram_rd_initiator_pkg.sv
// Shared types for the BRAM read initiator: encoding of the per-cycle tag FIFO operation.
package bram_rd_initiator_pkg;

  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_POP  = 2'b01,
    FIFO_PUSH = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(input logic push, input logic pop);
    return fifo_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/tag_fifo.sv
// Synchronous tag FIFO; full/empty come from registered occupancy only, no push-to-head bypass.
module tag_fifo
  import bram_rd_initiator_pkg::*;
#(
  parameter int W_TAG = 4,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [W_TAG-1:0] push_data_i,
  input  logic             pop_i,
  output logic [W_TAG-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [W_TAG-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_en, pop_en;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;

  // Pointers are power-of-two wide, so plain increment wraps modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    case (fifo_op(push_en, pop_en))
      FIFO_PUSH: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = count_q + 1'b1;
      end
      FIFO_POP: begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        count_d  = count_q - 1'b1;
      end
      FIFO_BOTH: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/bram_rd_initiator.sv
// Requester side of the valid/ready BRAM read port: forwards tagged reads and
// re-attaches each returned word to its tag in issue order.
module bram_rd_initiator
  import bram_rd_initiator_pkg::*;
#(
  parameter int W_DATA    = 16,
  parameter int W_ADDR    = 8,
  parameter int W_TAG     = 4,
  parameter int MAX_OUTST = 4,
  localparam int CW = $clog2(MAX_OUTST + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [W_ADDR-1:0] req_addr,
  input  logic [W_TAG-1:0]  req_tag,
  output logic              addr1_valid,
  input  logic              addr1_ready,
  output logic [W_ADDR-1:0] addr1_data,
  input  logic              data1_valid,
  output logic              data1_ready,
  input  logic [W_DATA-1:0] data1,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [W_DATA-1:0] resp_data,
  output logic [W_TAG-1:0]  resp_tag,
  output logic [CW-1:0]     outstanding,
  output logic              err
);

  logic full, empty;
  logic issue_fire, resp_fire;
  logic err_q, err_d;

  assign addr1_valid = req_valid & ~full;
  assign req_ready   = addr1_ready & ~full;
  assign addr1_data  = req_addr;
  assign issue_fire  = req_valid & addr1_ready & ~full;

  assign resp_valid  = data1_valid & ~empty;
  assign data1_ready = resp_ready & ~empty;
  assign resp_data   = data1;
  assign resp_fire   = data1_valid & resp_ready & ~empty;

  tag_fifo #(
    .W_TAG (W_TAG),
    .DEPTH (MAX_OUTST)
  ) u_tag_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (issue_fire),
    .push_data_i (req_tag),
    .pop_i       (resp_fire),
    .head_o      (resp_tag),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (outstanding)
  );

  // Read data with nothing in flight means the memory broke ordering; latch it.
  assign err_d = err_q | (data1_valid & empty);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: doc/bram_rd_initiator.md
# bram_rd_initiator

Requester-side endpoint of the valid/ready BRAM read protocol (`addr1_*` out, `data1_*` in) used by the ROM/BRAM memory wrappers such as the square-root table. It accepts tagged read requests from a client stage and issues them to the memory port. It tracks up to `MAX_OUTST` in-flight reads, then re-associates each returned word with its tag in issue order. Typical placement is between the variance-normalisation stage of the classifier datapath and the sqrt memory.

## Interface
Parameters:
- `W_DATA`, 16, memory data width
- `W_ADDR`, 8, memory address width
- `W_TAG`, 4, client tag width carried alongside each request
- `MAX_OUTST`, 4, maximum in-flight reads; power of two, ≥ 2

Ports:
- `clk`  in  1  clock; single clock domain
- `rst`  in  1  reset; synchronous, active-high
- `req_valid`  in  1  client request valid
- `req_ready`  out  1  client request accepted this cycle when high with `req_valid`
- `req_addr`  in  `W_ADDR`  read address
- `req_tag`  in  `W_TAG`  tag returned with the data
- `addr1_valid`  out  1  address valid to memory
- `addr1_ready`  in  1  memory accepts address
- `addr1_data`  out  `W_ADDR`  address to memory
- `data1_valid`  in  1  memory read data valid
- `data1_ready`  out  1  initiator accepts read data
- `data1`  in  `W_DATA`  memory read data
- `resp_valid`  out  1  tagged response valid
- `resp_ready`  in  1  downstream accepts response
- `resp_data`  out  `W_DATA`  read data
- `resp_tag`  out  `W_TAG`  tag of the request that produced `resp_data`
- `outstanding`  out  `$clog2(MAX_OUTST+1)`  current in-flight count
- `err`  out  1  sticky protocol error flag

## Operation
- Internal tag FIFO, depth `MAX_OUTST`; `outstanding` equals the FIFO occupancy.
- `full = (outstanding == MAX_OUTST)` and `empty = (outstanding == 0)` are both computed from registered occupancy only; a same-cycle pop does not free a slot.
- Request path, combinational pass-through:
  - `addr1_valid = req_valid & ~full`
  - `req_ready = addr1_ready & ~full`
  - `addr1_data = req_addr`
- Issue fire is `req_valid & addr1_ready & ~full`. On issue fire, `req_tag` is pushed.
- Response path:
  - `resp_valid = data1_valid & ~empty`
  - `data1_ready = resp_ready & ~empty`
  - `resp_data = data1`
  - `resp_tag` = FIFO head
- Response fire is `data1_valid & resp_ready & ~empty`. On response fire, the FIFO head is popped.
- Simultaneous issue and response fire: push and pop both happen and `outstanding` is unchanged. The pushed tag never appears at the head in the same cycle; there is no bypass.
- `data1_valid` while `empty` is a memory-side protocol violation. Response: `err` sets on the next edge and holds until `rst`. `data1_ready` stays 0 and nothing propagates.
- Responses are strictly in issue order. The memory side must be in-order; tags are not compared against the returned data.

## Timing
- Zero added latency on either path: the memory's own read latency is seen unchanged on `resp_*`.
- Registered state: FIFO storage, read pointer, write pointer, occupancy, `err`. All other outputs are combinational from this state and the inputs.
- Reset values (cycle after `rst` sampled high):
  - `outstanding` = 0, pointers = 0, `err` = 0
  - `req_ready` = `addr1_ready`
  - `addr1_valid` = `req_valid`
  - `resp_valid` = 0, `data1_ready` = 0
- Reset mid-operation discards all in-flight tags. The memory wrapper shares `rst` and drops its in-flight word in the same cycle.
- Pointers wrap modulo `MAX_OUTST`. Occupancy runs 0..`MAX_OUTST` inclusive, hence the extra bit.
- Client-facing rule: once `req_valid` is high it must hold stable until `req_ready`. Memory-facing rule: `addr1_valid`/`addr1_data` therefore also hold stable until `addr1_ready`.

## Structure
- Shared package: no new entries. Widths come from parameters; the count width is a local `localparam` computed with `$clog2(MAX_OUTST+1)`.
- One sub-module, `tag_fifo`: a synchronous FIFO of width `W_TAG` and depth `MAX_OUTST`, with push/pop/full/empty/count outputs and the same `clk`/`rst`. The top level holds only the handshake gating and the `err` flag.

## Test plan
- Single read: issue addr 0x10 tag 3 with a 1-cycle-latency memory returning 0x0004 → one response `resp_data`=0x0004, `resp_tag`=3; `outstanding` goes 0→1→0.
- Back-to-back burst: issue 6 requests (tags 0..5) with `MAX_OUTST`=4 while memory stalls returns → exactly 4 accepted, `req_ready`=0 while `outstanding`=4. Responses come out as tags 0,1,2,3,4,5 in order.
- Full with simultaneous pop: at `outstanding`=4, request valid and response fire in the same cycle → request not accepted that cycle (`req_ready`=0); accepted the next cycle; `outstanding` goes 4→3→4.
- Downstream backpressure: `resp_ready`=0 for 5 cycles with `data1_valid`=1 → `data1_ready`=0, response held stable; it drains on the first cycle `resp_ready`=1.
- Protocol error: `data1_valid`=1 with `outstanding`=0 → `err`=1 next cycle and stays 1; `resp_valid`=0; `err` clears only after `rst`.
- Reset mid-flight: 3 requests outstanding, assert `rst` one cycle → `outstanding`=0, `resp_valid`=0, `err`=0; a subsequent request with tag 7 returns tag 7.
